// File: rtl/mem_fill_pkg.sv
// Shared types for the SDPB fill/copy DMA: job modes, FSM states, limits.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_fill_pkg;

  // Deepest source read latency the delay line is sized and tested for.
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    CONST = 2'd0,
    INCR  = 2'd1,
    COPY  = 2'd2,
    RSVD  = 2'd3
  } fill_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_COPY  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } fill_state_e;

endpackage

// File: rtl/mem_fill_dma_rdpipe.sv
// Delay line pairing each source read with its destination write address.
// Latency: RD_LAT cycles from in_vld/in_addr to out_vld/out_addr.
// Backpressure: none; shifts every cycle, flushed only by rst_n.
// Ports: in_vld/in_addr = read issued this cycle and its destination address;
//        out_vld/out_addr = write due this cycle; pend = entries still behind the head.
module mem_fill_rdpipe
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 2   // 1..RD_LAT_MAX
) (
  input  logic              MEMORY_CLK,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_vld,
  output logic [ADDR_W-1:0] out_addr,
  output logic              pend
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [ADDR_W-1:0] addr_d [RD_LAT];

  always_comb begin
    vld_d[0]  = in_vld;
    addr_d[0] = in_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
  end

  // Valid entries not yet at the head: once this is clear, the head entry
  // (if any) is the final write and the job can finish next cycle.
  always_comb begin
    pend = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      pend = pend | vld_q[i];
    end
  end

  always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
    end
  end

  assign out_vld  = vld_q[RD_LAT-1];
  assign out_addr = addr_q[RD_LAT-1];

endmodule

// File: rtl/mem_fill_dma.sv
// Block-RAM initialiser/copier: CONST/INCR fill or COPY into one SDPB write port.
// Latency: fill write i on cycle 1+i after start; copy write k on cycle 1+k+RD_LAT.
// Backpressure: none; 1 word/clock, start ignored while busy, mode=3 rejected via err.
// Ports: start/mode/base_addr/src_addr/length/seed/mask = command (sampled in IDLE);
//        busy/done/err = status; dst_* = destination write port; src_* = source read port.
module mem_fill_dma
  import mem_fill_pkg::*;
#(
  parameter int              ADDR_W     = 10,
  parameter int              DATA_W     = 8,
  parameter int              RD_LAT     = 2,
  parameter int              AUTO_START = 1,
  parameter int              AUTO_LEN   = 1024,
  parameter logic [DATA_W-1:0] AUTO_MASK = 8'h7F
) (
  input  logic              MEMORY_CLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] mask,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] dst_ada,
  output logic [DATA_W-1:0] dst_din,
  output logic              dst_cea,
  output logic [ADDR_W-1:0] src_adb,
  output logic              src_ceb,
  output logic              src_oce,
  input  logic [DATA_W-1:0] src_dout
);

  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [DATA_W-1:0] DATA_ONE   = DATA_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   AUTO_LEN_C = (ADDR_W+1)'(AUTO_LEN);

  fill_state_e       state_q, state_d;
  fill_mode_e        mode_q, mode_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;          // words still to launch after the current one
  logic [DATA_W-1:0] val_q, val_d;          // unmasked data for the next fill write
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;  // next fill destination address
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;  // source address being read this cycle
  logic [ADDR_W-1:0] rd_dst_q, rd_dst_d;    // destination paired with that read
  logic              rd_ceb_q, rd_ceb_d;
  logic              fill_cea_q, fill_cea_d;
  logic              err_q, err_d;
  logic              auto_q, auto_d;        // auto job still owed after reset
  logic [ADDR_W-1:0] ada_q, ada_d;          // last write address, held between writes
  logic [DATA_W-1:0] din_q, din_d;          // last write data, held between writes

  logic              pipe_vld;
  logic [ADDR_W-1:0] pipe_addr;
  logic              pipe_pend;

  // The pending auto job masquerades as a start strobe with fixed arguments.
  logic              cmd_go;
  fill_mode_e        cmd_mode;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W:0]   cmd_len;
  logic [DATA_W-1:0] cmd_seed;
  logic [DATA_W-1:0] cmd_mask;

  assign cmd_go   = start | auto_q;
  assign cmd_mode = auto_q ? INCR : fill_mode_e'(mode);
  assign cmd_base = auto_q ? '0 : base_addr;
  assign cmd_len  = auto_q ? AUTO_LEN_C : length;
  assign cmd_seed = auto_q ? '0 : seed;
  assign cmd_mask = auto_q ? AUTO_MASK : mask;

  function automatic logic [DATA_W-1:0] fill_word(input fill_mode_e m,
                                                  input logic [DATA_W-1:0] v,
                                                  input logic [DATA_W-1:0] msk);
    return (m == INCR) ? (v & msk) : v;
  endfunction

  mem_fill_rdpipe #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .MEMORY_CLK (MEMORY_CLK),
    .rst_n      (rst_n),
    .in_vld     (rd_ceb_q),
    .in_addr    (rd_dst_q),
    .out_vld    (pipe_vld),
    .out_addr   (pipe_addr),
    .pend       (pipe_pend)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    val_d      = val_q;
    mask_d     = mask_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    rd_dst_d   = rd_dst_q;
    rd_ceb_d   = 1'b0;
    fill_cea_d = 1'b0;
    err_d      = 1'b0;
    auto_d     = auto_q;
    ada_d      = ada_q;
    din_d      = din_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_go) begin
          auto_d = 1'b0;
          if (cmd_mode == RSVD) begin
            err_d = 1'b1;
          end else if (cmd_len == '0) begin
            state_d = ST_FIN;
          end else begin
            // First word is launched right here so it lands on cycle 1.
            cnt_d  = cmd_len - LEN_ONE;
            mode_d = cmd_mode;
            mask_d = cmd_mask;
            if (cmd_mode == COPY) begin
              state_d   = ST_COPY;
              rd_ceb_d  = 1'b1;
              rd_addr_d = src_addr;
              rd_dst_d  = cmd_base;
            end else begin
              state_d    = ST_FILL;
              fill_cea_d = 1'b1;
              ada_d      = cmd_base;
              din_d      = fill_word(cmd_mode, cmd_seed, cmd_mask);
              wr_addr_d  = cmd_base + ADDR_ONE;
              val_d      = (cmd_mode == INCR) ? cmd_seed + DATA_ONE : cmd_seed;
            end
          end
        end
      end
      ST_FILL: begin
        if (cnt_q != '0) begin
          fill_cea_d = 1'b1;
          ada_d      = wr_addr_q;
          din_d      = fill_word(mode_q, val_q, mask_q);
          wr_addr_d  = wr_addr_q + ADDR_ONE;
          if (mode_q == INCR) val_d = val_q + DATA_ONE;
          cnt_d      = cnt_q - LEN_ONE;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_COPY: begin
        if (cnt_q != '0) begin
          rd_ceb_d  = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_ONE;
          rd_dst_d  = rd_dst_q + ADDR_ONE;
          cnt_d     = cnt_q - LEN_ONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Nothing behind the head means this cycle carries the last write.
        if (!pipe_pend) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Copy writes go out combinationally with src_dout; latch them so the
    // port holds the last written address/data afterwards.
    if (pipe_vld) begin
      ada_d = pipe_addr;
      din_d = src_dout;
    end
  end

  always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= CONST;
      cnt_q      <= '0;
      val_q      <= '0;
      mask_q     <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rd_dst_q   <= '0;
      rd_ceb_q   <= 1'b0;
      fill_cea_q <= 1'b0;
      err_q      <= 1'b0;
      auto_q     <= (AUTO_START != 0);
      ada_q      <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      val_q      <= val_d;
      mask_q     <= mask_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      rd_dst_q   <= rd_dst_d;
      rd_ceb_q   <= rd_ceb_d;
      fill_cea_q <= fill_cea_d;
      err_q      <= err_d;
      auto_q     <= auto_d;
      ada_q      <= ada_d;
      din_q      <= din_d;
    end
  end

  assign busy    = state_q inside {ST_FILL, ST_COPY, ST_DRAIN};
  assign done    = (state_q == ST_FIN);
  assign err     = err_q;
  assign dst_cea = fill_cea_q | pipe_vld;
  assign dst_ada = pipe_vld ? pipe_addr : ada_q;
  assign dst_din = pipe_vld ? src_dout : din_q;
  assign src_ceb = rd_ceb_q;
  assign src_adb = rd_addr_q;
  // Source output register is always enabled; RD_LAT already counts it.
  assign src_oce = 1'b1;

endmodule

// File: tb/tb_mem_fill_dma.sv
module tb_mem_fill_dma;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int RDL   = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] src_addr = '0;
  logic [AW:0]   length = '0;
  logic [DW-1:0] seed = '0;
  logic [DW-1:0] mask = '0;
  logic          busy, done, err, dst_cea, src_ceb, src_oce;
  logic [AW-1:0] dst_ada, src_adb;
  logic [DW-1:0] dst_din, src_dout;

  always #5 clk = ~clk;

  mem_fill_dma #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL),
    .AUTO_START(1), .AUTO_LEN(1024), .AUTO_MASK(8'h7F)
  ) dut (
    .MEMORY_CLK(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .base_addr(base_addr), .src_addr(src_addr), .length(length),
    .seed(seed), .mask(mask), .busy(busy), .done(done), .err(err),
    .dst_ada(dst_ada), .dst_din(dst_din), .dst_cea(dst_cea),
    .src_adb(src_adb), .src_ceb(src_ceb), .src_oce(src_oce),
    .src_dout(src_dout)
  );

  // Source SDPB: address register then output register (2-cycle read).
  logic [DW-1:0] src_mem [DEPTH];
  logic [DW-1:0] rd1 = '0, rd2 = '0;
  always @(posedge clk) begin
    if (src_ceb) rd1 <= src_mem[src_adb];
    if (src_oce) rd2 <= rd1;
  end
  assign src_dout = rd2;

  // Destination RAM image and per-job observation, owned by the monitor.
  logic [DW-1:0] dut_mem [DEPTH] = '{default: 8'hEE};
  logic [DW-1:0] exp_mem [DEPTH] = '{default: 8'hEE};
  int ncyc = 0, t0 = 0, job_id = 0, seen_id = 0;
  int wr_count = 0, first_wr = -1, last_wr = -1, busy_cnt = 0, first_busy = -1;
  int done_count = 0, done_cyc = -1, err_count = 0, err_cyc = -1;
  int n_cmp = 0, n_bad = 0;

  always @(negedge clk) begin
    int cur;
    if (seen_id != job_id) begin
      seen_id = job_id;
      wr_count = 0; first_wr = -1; last_wr = -1; busy_cnt = 0; first_busy = -1;
      done_count = 0; done_cyc = -1; err_count = 0; err_cyc = -1;
    end
    cur = ncyc - t0;
    if (dst_cea) begin
      dut_mem[dst_ada] = dst_din;
      wr_count++;
      if (first_wr < 0) first_wr = cur;
      last_wr = cur;
    end
    if (busy) begin
      busy_cnt++;
      if (first_busy < 0) first_busy = cur;
    end
    if (done) begin done_count++; done_cyc = cur; end
    if (err)  begin err_count++;  err_cyc = cur;  end
    ncyc++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (dut_mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  // Reference: what the destination RAM must hold after a job.
  task automatic model_job(input int m, input int b, input int s, input int len,
                           input int sd, input int mk);
    for (int k = 0; k < len; k++) begin
      int a;
      a = (b + k) % DEPTH;
      if (m == 2)      exp_mem[a] = src_mem[(s + k) % DEPTH];
      else if (m == 1) exp_mem[a] = DW'((sd + k) & mk);
      else             exp_mem[a] = DW'(sd);
    end
  endtask

  task automatic model_auto();
    for (int n = 0; n < DEPTH; n++) exp_mem[n] = DW'(n & 8'h7F);
  endtask

  task automatic issue(input int m, input int b, input int s, input int len,
                       input int sd, input int mk, input bit new_job);
    @(posedge clk); #1;
    start = 1'b1; mode = 2'(m); base_addr = AW'(b); src_addr = AW'(s);
    length = (AW+1)'(len); seed = DW'(sd); mask = DW'(mk);
    if (new_job) begin job_id++; t0 = ncyc; end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int limit);
    int i = 0;
    while (i < limit && done_count == 0 && err_count == 0) begin
      @(posedge clk); i++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_finished"}, int'((done_count + err_count) > 0), 1);
  endtask

  task automatic check_job(input string tag, input int m, input int len);
    int exp_done;
    exp_done = (len == 0) ? 1 : ((m == 2) ? len + RDL + 1 : len + 1);
    chk({tag, "_done_cnt"}, done_count, 1);
    chk({tag, "_done_cyc"}, done_cyc, exp_done);
    chk({tag, "_err_cnt"}, err_count, 0);
    chk({tag, "_wr_cnt"}, wr_count, len);
    chk({tag, "_busy_cnt"}, busy_cnt, exp_done - 1);
    if (len > 0) begin
      chk({tag, "_first_busy"}, first_busy, 1);
      chk({tag, "_first_wr"}, first_wr, (m == 2) ? 1 + RDL : 1);
      chk({tag, "_wr_span"}, last_wr - first_wr, len - 1);
    end
    chk({tag, "_mem_diff"}, mem_diff(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) src_mem[i] = DW'($urandom);

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_busy_done_err", 32'({busy, done, err}), 0);
    chk("rst_dst", 32'({dst_cea, dst_ada, dst_din}), 0);
    chk("rst_src", 32'({src_ceb, src_adb}), 0);
    chk("rst_oce", 32'(src_oce), 1);

    // Auto-start INCR fill of the whole RAM
    @(posedge clk); #1;
    rst_n = 1'b1; job_id++; t0 = ncyc;
    model_auto();
    wait_end("auto", 2000);
    check_job("auto", 1, 1024);
    chk("auto_7f", 32'(dut_mem[10'h07F]), 'h7F);
    chk("auto_80", 32'(dut_mem[10'h080]), 'h00);
    chk("auto_3ff", 32'(dut_mem[10'h3FF]), 'h7F);

    // CONST fill
    issue(0, 'h100, 0, 40, 'h20, 'hFF, 1'b1);
    model_job(0, 'h100, 0, 40, 'h20, 'hFF);
    wait_end("const", 200);
    check_job("const", 0, 40);
    chk("const_127", 32'(dut_mem[10'h127]), 'h20);
    chk("const_0ff", 32'(dut_mem[10'h0FF]), 'h7F);
    chk("const_128", 32'(dut_mem[10'h128]), 'h28);

    // COPY from preloaded source
    for (int k = 0; k < 8; k++) src_mem['h010 + k] = DW'('hA0 + k);
    issue(2, 'h200, 'h010, 8, 0, 0, 1'b1);
    model_job(2, 'h200, 'h010, 8, 0, 0);
    wait_end("copy", 200);
    check_job("copy", 2, 8);
    chk("copy_200", 32'(dut_mem[10'h200]), 'hA0);
    chk("copy_207", 32'(dut_mem[10'h207]), 'hA7);

    // INCR wrapping the address space
    issue(1, 'h3FE, 0, 4, 'hFE, 'hFF, 1'b1);
    model_job(1, 'h3FE, 0, 4, 'hFE, 'hFF);
    wait_end("wrap", 200);
    check_job("wrap", 1, 4);
    chk("wrap_3ff", 32'(dut_mem[10'h3FF]), 'hFF);
    chk("wrap_000", 32'(dut_mem[10'h000]), 'h00);
    chk("wrap_001", 32'(dut_mem[10'h001]), 'h01);

    // Zero length
    issue(0, 'h050, 0, 0, 'h99, 'hFF, 1'b1);
    wait_end("len0", 200);
    check_job("len0", 0, 0);

    // Reserved mode
    issue(3, 'h060, 0, 5, 'h11, 'hFF, 1'b1);
    wait_end("rsvd", 50);
    chk("rsvd_err_cnt", err_count, 1);
    chk("rsvd_err_cyc", err_cyc, 1);
    chk("rsvd_wr_cnt", wr_count, 0);
    chk("rsvd_done_cnt", done_count, 0);
    chk("rsvd_busy_cnt", busy_cnt, 0);
    chk("rsvd_mem_diff", mem_diff(), 0);

    // Start while busy is ignored
    issue(1, 'h050, 0, 30, 3, 'h3F, 1'b1);
    model_job(1, 'h050, 0, 30, 3, 'h3F);
    repeat (4) @(posedge clk);
    issue(0, 'h380, 0, 5, 'h55, 'hFF, 1'b0);
    wait_end("busy_start", 200);
    check_job("busy_start", 1, 30);

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      int m, b, s, len, sd, mk;
      m   = $urandom_range(0, 2);
      b   = $urandom_range(0, DEPTH - 1);
      s   = $urandom_range(0, DEPTH - 1);
      len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 60);
      sd  = $urandom_range(0, 255);
      mk  = $urandom_range(0, 255);
      issue(m, b, s, len, sd, mk, 1'b1);
      model_job(m, b, s, len, sd, mk);
      wait_end($sformatf("rnd%0d", j), 300);
      check_job($sformatf("rnd%0d_m%0d_l%0d", j, m, len), m, len);
    end

    // Reset in the middle of a COPY
    issue(2, 'h300, 'h000, 200, 0, 0, 1'b1);
    repeat (20) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_cea", 32'(dst_cea), 0);
    chk("midrst_busy", 32'(busy), 0);
    job_id++;
    repeat (6) @(posedge clk); #1;
    chk("midrst_wr_cnt", wr_count, 0);
    chk("midrst_done_cnt", done_count, 0);
    rst_n = 1'b1; job_id++; t0 = ncyc;
    model_auto();
    wait_end("auto2", 2000);
    check_job("auto2", 1, 1024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
